// File: rtl/cu_fsm.sv
// Multi-cycle RV32I control unit: INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Only the state is registered; every strobe is decoded from state and live inputs.
module cu_fsm (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       intr,
  input  logic       csr_mie,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       rst,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RG3    = 7'b0110011;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } state_t;

  state_t state, next_state;
  logic   irq_req;
  logic   is_mret;

  always_comb begin
    irq_req = intr & csr_mie;
    is_mret = (opcode == OP_SYSTEM) && (func3 == 3'b000);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_INIT:  next_state = ST_FETCH;
      ST_FETCH: if (mem_ready) next_state = ST_EXEC;
      ST_EXEC: begin
        // MRET never chains straight into interrupt entry
        if (opcode == OP_LOAD)         next_state = ST_WB;
        else if (irq_req && !is_mret)  next_state = ST_INTR;
        else                           next_state = ST_FETCH;
      end
      ST_WB:    if (mem_ready) next_state = irq_req ? ST_INTR : ST_FETCH;
      ST_INTR:  next_state = ST_FETCH;
      default:  next_state = ST_INIT;
    endcase
  end

  always_comb begin
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    rst       = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    unique case (state)
      ST_INIT:  rst = 1'b1;
      ST_FETCH: memRDEN1 = 1'b1;
      ST_EXEC: begin
        case (opcode)
          OP_LOAD:   memRDEN2 = 1'b1;
          OP_STORE: begin
            memWE2  = 1'b1;
            pcWrite = 1'b1;
          end
          OP_BRANCH: pcWrite = 1'b1;
          OP_SYSTEM: begin
            pcWrite = 1'b1;
            if (func3 == 3'b001) begin
              csr_WE   = 1'b1;
              regWrite = 1'b1;
            end else if (func3 == 3'b000) begin
              mret_exec = 1'b1;
            end
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: begin
            regWrite = 1'b1;
            pcWrite  = 1'b1;
          end
          default:   pcWrite = 1'b1;
        endcase
      end
      ST_WB: begin
        memRDEN2 = 1'b1;
        regWrite = mem_ready;
        pcWrite  = mem_ready;
      end
      ST_INTR: begin
        int_taken = 1'b1;
        pcWrite   = 1'b1;
      end
      default:  rst = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: each instruction is expanded into its expected per-cycle
// strobe pattern, queued, and compared by an independent monitor on the falling edge.
module tb_cu_fsm;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic rst, rden1, rden2, we2, pcw, rgw, csrwe, intk, mret;
  } outv_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       intr, csr_mie, mem_ready;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       pcWrite, regWrite, memWE2, memRDEN1, memRDEN2;
  logic       rst, csr_WE, int_taken, mret_exec;

  outv_t exp_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  bit    running = 1'b0;

  cu_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .intr(intr), .csr_mie(csr_mie),
    .opcode(opcode), .func3(func3), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .regWrite(regWrite), .memWE2(memWE2),
    .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .rst(rst),
    .csr_WE(csr_WE), .int_taken(int_taken), .mret_exec(mret_exec)
  );

  always #5 CLK = ~CLK;

  function automatic outv_t actual();
    outv_t a;
    a = '{rst, memRDEN1, memRDEN2, memWE2, pcWrite, regWrite, csr_WE, int_taken, mret_exec};
    return a;
  endfunction

  function automatic outv_t only_rst();
    outv_t e;
    e = '0;
    e.rst = 1'b1;
    return e;
  endfunction

  // Strobes an instruction raises in its execute cycle, straight from the opcode table
  function automatic outv_t exec_expect(input logic [6:0] op, input logic [2:0] f3);
    outv_t e;
    e = '0;
    case (op)
      OP_LOAD:   e.rden2 = 1'b1;
      OP_STORE:  begin e.we2 = 1'b1; e.pcw = 1'b1; end
      OP_BRANCH: e.pcw = 1'b1;
      OP_SYSTEM: begin
        e.pcw = 1'b1;
        if (f3 == 3'b001) begin e.csrwe = 1'b1; e.rgw = 1'b1; end
        if (f3 == 3'b000) e.mret = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011:
        begin e.rgw = 1'b1; e.pcw = 1'b1; end
      default:   e.pcw = 1'b1;
    endcase
    return e;
  endfunction

  task automatic noise();
    intr    = 1'($urandom);
    csr_mie = 1'($urandom);
    opcode  = 7'($urandom);
    func3   = 3'($urandom);
  endtask

  task automatic cycle_push(input outv_t e);
    exp_q.push_back(e);
  endtask

  // Reset already asserted in the current cycle; hold one more cycle, then release
  task automatic finish_reset();
    @(posedge CLK); #1;
    cycle_push(only_rst());
    @(posedge CLK); #1;
    RST_N = 1'b1;
    cycle_push(only_rst());
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input int unsigned fw, input int unsigned ww,
                           input logic ix, input logic mx, input bit abort);
    outv_t e;
    bit    take;
    for (int unsigned i = 0; i <= fw; i++) begin
      @(posedge CLK); #1;
      noise();
      mem_ready = (i == fw);
      e = '0; e.rden1 = 1'b1;
      cycle_push(e);
    end
    @(posedge CLK); #1;
    noise();
    opcode    = op;
    func3     = f3;
    mem_ready = 1'($urandom);
    if (op != OP_LOAD) begin intr = ix; csr_mie = mx; end
    cycle_push(exec_expect(op, f3));
    if (op == OP_LOAD) begin
      for (int unsigned i = 0; i <= ww; i++) begin
        @(posedge CLK); #1;
        noise();
        if (abort) begin
          mem_ready = 1'b0;
          RST_N     = 1'b0;
          cycle_push(only_rst());
          #1;
          n_cmp++;
          if (actual() !== only_rst()) begin
            n_mis++;
            $display("FAIL reset_mid_wb: got %b want %b", actual(), only_rst());
          end
          finish_reset();
          return;
        end
        mem_ready = (i == ww);
        e = '0; e.rden2 = 1'b1;
        if (i == ww) begin
          intr = ix; csr_mie = mx;
          e.rgw = 1'b1; e.pcw = 1'b1;
        end
        cycle_push(e);
      end
    end
    take = ix && mx && !(op == OP_SYSTEM && f3 == 3'b000);
    if (take) begin
      @(posedge CLK); #1;
      noise();
      mem_ready = 1'($urandom);
      e = '0; e.intk = 1'b1; e.pcw = 1'b1;
      cycle_push(e);
    end
  endtask

  always @(negedge CLK) begin
    if (running) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL monitor_underrun: got %b want <queued expectation>", actual());
      end else begin
        outv_t e;
        e = exp_q.pop_front();
        if (actual() !== e) begin
          n_mis++;
          $display("FAIL cycle_strobes @%0t: got %b want %b (rst,rd1,rd2,we2,pcw,rgw,csrwe,intk,mret)",
                   $time, actual(), e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops [11];
    logic [6:0] op;
    logic [2:0] f3;
    ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011, 7'b0000000};
    RST_N = 1'b0;
    intr = 1'b0; csr_mie = 1'b0; mem_ready = 1'b0; opcode = '0; func3 = '0;
    running = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      noise();
      mem_ready = 1'($urandom);
      cycle_push(only_rst());
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    cycle_push(only_rst());

    run_instr(7'b0010011, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_LOAD,    3'b010, 0, 2, 1'b0, 1'b0, 1'b0);
    run_instr(OP_STORE,   3'b010, 0, 0, 1'b1, 1'b1, 1'b0);
    run_instr(OP_STORE,   3'b010, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(OP_SYSTEM,  3'b000, 0, 0, 1'b1, 1'b1, 1'b0);
    run_instr(OP_LOAD,    3'b010, 1, 2, 1'b1, 1'b1, 1'b1);
    run_instr(OP_LOAD,    3'b000, 2, 0, 1'b1, 1'b1, 1'b0);

    for (int unsigned n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 10) == 0) op = 7'($urandom);
      f3 = 3'($urandom);
      if (op == OP_SYSTEM && $urandom_range(0, 1) == 1) f3 = 3'($urandom_range(0, 1));
      run_instr(op, f3, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom),
                (op == OP_LOAD) && ($urandom_range(0, 24) == 0));
    end

    @(negedge CLK); #1;
    running = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cu_fsm.md
CU_FSM -- requirements
Module: cu_fsm

Interface
REQ-001 SHALL have parameters: none; all encodings fixed (RV32I opcodes: LOAD 0000011, STORE 0100011, BRANCH 1100011, SYSTEM 1110011; all others are non-memory).
REQ-002 SHALL have ports, clock and reset first: CLK in 1, system clock, rising edge.
REQ-003 SHALL have: RST_N in 1, asynchronous active-low reset.
REQ-004 SHALL have: intr in 1, external interrupt request, level-sensitive.
REQ-005 SHALL have: csr_mie in 1, interrupt enable from the CSR file.
REQ-006 SHALL have: opcode in 7, ir[6:0]; func3 in 3, ir[14:12].
REQ-007 SHALL have: mem_ready in 1, memory has completed the current instruction fetch or data read.
REQ-008 SHALL have: pcWrite out 1, PC load enable.
REQ-009 SHALL have: regWrite out 1, register-file write enable.
REQ-010 SHALL have: memWE2 out 1, data write; memRDEN1 out 1, instruction read; memRDEN2 out 1, data read.
REQ-011 SHALL have: rst out 1, datapath reset; csr_WE out 1, CSR write; int_taken out 1, interrupt entry; mret_exec out 1, MRET execution.

Function
REQ-012 SHALL implement five states: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR.
REQ-013 SHALL register only the state; all outputs are combinational in the current state and inputs; any output not listed for a state is 0.
REQ-014 ST_INIT: rst=1; next state is ST_FETCH unconditionally, so it lasts exactly 1 cycle after RST_N deasserts.
REQ-015 ST_FETCH: memRDEN1=1; mem_ready=1 -> ST_EXEC; mem_ready=0 -> stay in ST_FETCH with memRDEN1 held high (no limit on wait states).
REQ-016 ST_EXEC, opcode LOAD: memRDEN2=1, pcWrite=0, regWrite=0; next state ST_WB.
REQ-017 ST_EXEC, opcode STORE: memWE2=1, pcWrite=1 for exactly 1 cycle.
REQ-018 ST_EXEC, opcode BRANCH: pcWrite=1, regWrite=0.
REQ-019 ST_EXEC, opcode SYSTEM with func3=001 (CSRRW): csr_WE=1, regWrite=1, pcWrite=1.
REQ-020 ST_EXEC, opcode SYSTEM with func3=000 (MRET): mret_exec=1, pcWrite=1, regWrite=0.
REQ-021 ST_EXEC, opcode SYSTEM with any other func3: pcWrite=1 only.
REQ-022 ST_EXEC, LUI/AUIPC/JAL/JALR/OP_IMM/OP_RG3: regWrite=1, pcWrite=1.
REQ-023 ST_EXEC, undefined opcode: pcWrite=1 only (executes as NOP), so the FSM never stalls on a bad opcode.
REQ-024 ST_WB: memRDEN2=1 held. On mem_ready=1: regWrite=1, pcWrite=1, and the state advances. On mem_ready=0: stay in ST_WB with regWrite=pcWrite=0.
REQ-025 Exit of ST_EXEC (non-LOAD) or ST_WB (with mem_ready=1): go to ST_INTR if (intr & csr_mie)=1, else to ST_FETCH. Both inputs are sampled in that same exit cycle.
REQ-026 MRET in ST_EXEC SHALL NOT go to ST_INTR in the same exit, regardless of intr, so interrupt entry and return are never back-to-back.
REQ-027 ST_INTR: int_taken=1, pcWrite=1 for exactly 1 cycle; next state ST_FETCH.
REQ-028 intr SHALL NOT be latched; a pulse that falls before an exit point is ignored.
REQ-029 Interrupts SHALL NOT be taken in ST_INIT or ST_FETCH, or in ST_WB while mem_ready=0.
REQ-030 At most one of memWE2, memRDEN1, memRDEN2 SHALL be high in any cycle.
REQ-031 pcWrite SHALL be high for exactly one cycle per retired instruction, plus one per interrupt entry.

Reset
REQ-032 RST_N=0 SHALL force ST_INIT asynchronously, including mid-FETCH, mid-WB or in ST_INTR.
REQ-033 While RST_N=0: rst=1 and all other outputs 0; pending memory strobes drop immediately.
REQ-034 Leaving reset, the first rising edge after RST_N rises SHALL move ST_INIT to ST_FETCH.

Verification
REQ-035 Reset then ADDI (0010011), mem_ready=1 always -> cycle 0 rst=1; cycle 1 memRDEN1=1; cycle 2 regWrite=pcWrite=1; cycle 3 memRDEN1=1.
REQ-036 LOAD with mem_ready low 2 cycles in ST_WB -> memRDEN2=1 for 4 cycles; regWrite=pcWrite=1 only in the final cycle.
REQ-037 STORE with intr=1, csr_mie=1 -> memWE2=pcWrite=1 in EXEC; next cycle int_taken=pcWrite=1; then memRDEN1=1.
REQ-038 Same as REQ-037 with csr_mie=0 -> int_taken never asserts; next state ST_FETCH.
REQ-039 MRET (1110011, func3=000) with intr=1, csr_mie=1 -> mret_exec=pcWrite=1; next state ST_FETCH with int_taken=0.
REQ-040 RST_N pulsed low mid-ST_WB -> outputs drop at once (rst=1), no regWrite occurs, and the FSM restarts at ST_INIT.
